tiny_calc: RTL and testbench

Clocked, parametrised successor to the four-bit push-button adder: operands are entered on switches and stepped with an EXEC button, and the result drives a bank of hex 7-segment digits. It adds synchronised and debounced buttons, configurable operand width and digit count, a carry/borrow flag, and optional subtraction. It is the top-level datapath for TinyFPGA BX calculator builds, reusing the existing `segment7` decoder per digit.

---
 rtl/tiny_calc.sv | 240 ++++++++++++++++++++++++
 tb/tb_tiny_calc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tiny_calc.sv
// ============================================================================
// Module   : tiny_calc (with segment7 digit decoder)
// Brief    : Push-button calculator datapath. Two operands are entered on the
//            switches and stepped with EXEC. The result is shown on hex
//            7-segment digits. Subtraction is built only when TINY_CALC_SUB_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module segment7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    // The segment order is {G,F,E,D,C,B,A}. A 1 lights the segment.
    always_comb begin
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end
endmodule

module tiny_calc #(
    parameter int WIDTH           = 4,
    parameter int DIGITS          = 2,
    parameter int DEBOUNCE_CYCLES = 160000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [WIDTH-1:0]      SW,
    input  logic                  EXEC_N,
    input  logic                  CLR_N,
`ifdef TINY_CALC_SUB_EN
    input  logic                  OP,
`endif
    output logic [7*DIGITS-1:0]   SEG,
    output logic [1:0]            STATE,
    output logic                  OVF,
    output logic                  LED,
    output logic                  USBPU
);

    localparam int                DISP_W   = 4 * DIGITS;
    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_A   = 2'b00;
    localparam logic [1:0] S_B   = 2'b01;
    localparam logic [1:0] S_SUM = 2'b10;

    logic [1:0]       btn_raw;
    logic [1:0]       btn_s1;
    logic [1:0]       btn_s2;
    logic [1:0]       btn_db;
    logic [1:0]       btn_press;
    logic [CNT_W-1:0] btn_cnt [2];
    logic             exec_press;
    logic             clr_press;

    logic [WIDTH-1:0] sw_s1;
    logic [WIDTH-1:0] sw_s2;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   res;
    logic             ovf;
    logic             led;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   calc_res;
    logic             calc_ovf;
    logic [DISP_W-1:0]   disp;
    logic [7*DIGITS-1:0] seg_next;

    assign btn_raw    = {CLR_N, EXEC_N};
    assign exec_press = btn_press[0];
    assign clr_press  = btn_press[1];

    // The synchroniser and the debouncer for each button. A held button
    // starts as "released", so it produces one press after the debounce time.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_s1    <= 2'b11;
            btn_s2    <= 2'b11;
            btn_db    <= 2'b11;
            btn_press <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            btn_s1    <= btn_raw;
            btn_s2    <= btn_s1;
            btn_press <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == btn_db[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_cnt[i] == CNT_LAST) begin
                    btn_db[i]    <= btn_s2[i];
                    btn_cnt[i]   <= '0;
                    btn_press[i] <= ~btn_s2[i];
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= SW;
            sw_s2 <= sw_s1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_A;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clr_press) begin
            next_state = S_A;
        end else begin
            case (state)
                S_A:     if (exec_press) next_state = S_B;
                S_B:     if (exec_press) next_state = S_SUM;
                S_SUM:   if (exec_press) next_state = S_A;
                default: next_state = S_A;
            endcase
        end
    end

    // The second operand is the live switch value while B is being latched.
    assign op_b = (state == S_B) ? sw_s2 : b;

    always_comb begin
        calc_res = {1'b0, a} + {1'b0, op_b};
        calc_ovf = calc_res[WIDTH];
`ifdef TINY_CALC_SUB_EN
        if (OP) begin
            calc_res = {1'b0, a - op_b};
            calc_ovf = (a < op_b);
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a   <= '0;
            b   <= '0;
            res <= '0;
            ovf <= 1'b0;
            led <= 1'b0;
        end else if (clr_press) begin
            a   <= '0;
            b   <= '0;
            res <= '0;
            ovf <= 1'b0;
            led <= 1'b0;
        end else if (exec_press) begin
            case (state)
                S_A: a <= sw_s2;
                S_B: begin
                    b   <= sw_s2;
                    res <= calc_res;
                    ovf <= calc_ovf;
                    led <= 1'b1;
                end
                S_SUM: begin
                    a   <= '0;
                    b   <= '0;
                    res <= '0;
                    ovf <= 1'b0;
                    led <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        disp = '0;
        if (state == S_SUM) begin
            disp[WIDTH:0] = res;
        end else begin
            disp[WIDTH-1:0] = sw_s2;
        end
    end

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            segment7 u_seg (
                .hex (disp[4*d+3:4*d]),
                .seg (seg_next[7*d+6:7*d])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SEG <= {DIGITS{7'h3F}};
        end else begin
            SEG <= seg_next;
        end
    end

    assign STATE = state;
    assign OVF   = ovf;
    assign LED   = led;
    assign USBPU = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_tiny_calc.sv
// ============================================================================
// Module   : tb_tiny_calc
// Brief    : Directed bench for tiny_calc. It uses a 4-bit/2-digit instance
//            and an 8-bit/3-digit instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tiny_calc;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sw = 4'h0;
    logic        exec_n = 1'b1;
    logic        clr_n = 1'b1;
    logic        op = 1'b0;
    logic [13:0] seg;
    logic [1:0]  state;
    logic        ovf;
    logic        led;
    logic        usbpu;

    logic [7:0]  sw8 = 8'h00;
    logic        exec8_n = 1'b1;
    logic        clr8_n = 1'b1;
    logic [20:0] seg8;
    logic [1:0]  state8;
    logic        ovf8;
    logic        led8;
    logic        usbpu8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tiny_calc #(.WIDTH(4), .DIGITS(2), .DEBOUNCE_CYCLES(DB)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .SW     (sw),
        .EXEC_N (exec_n),
        .CLR_N  (clr_n),
`ifdef TINY_CALC_SUB_EN
        .OP     (op),
`endif
        .SEG    (seg),
        .STATE  (state),
        .OVF    (ovf),
        .LED    (led),
        .USBPU  (usbpu)
    );

    tiny_calc #(.WIDTH(8), .DIGITS(3), .DEBOUNCE_CYCLES(DB)) dut8 (
        .CLK    (clk),
        .RST_N  (rst_n),
        .SW     (sw8),
        .EXEC_N (exec8_n),
        .CLR_N  (clr8_n),
`ifdef TINY_CALC_SUB_EN
        .OP     (1'b0),
`endif
        .SEG    (seg8),
        .STATE  (state8),
        .OVF    (ovf8),
        .LED    (led8),
        .USBPU  (usbpu8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // btn: 0=EXEC, 1=CLR, 2=EXEC+CLR together, 3=EXEC on the 8-bit instance
    task automatic press(input int btn);
        @(negedge clk);
        case (btn)
            0: exec_n = 1'b0;
            1: clr_n = 1'b0;
            2: begin exec_n = 1'b0; clr_n = 1'b0; end
            default: exec8_n = 1'b0;
        endcase
        cyc(DB + 8);
        exec_n = 1'b1; clr_n = 1'b1; exec8_n = 1'b1;
        cyc(DB + 8);
    endtask

    initial begin
        cyc(3);
        chk("rst_state", state, 2'b00);
        chk("rst_led", led, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_usbpu", usbpu, 1'b0);
        chk("rst_seg", seg, {7'h3F, 7'h3F});
        chk("rst_seg8", seg8, {7'h3F, 7'h3F, 7'h3F});
        rst_n = 1'b1;
        cyc(5);

        // 9 + 8 = 0x11
        sw = 4'h9;
        cyc(5);
        chk("live_sw9", seg, {7'h3F, 7'h6F});
        press(0);
        chk("a_state", state, 2'b01);
        sw = 4'h8;
        press(0);
        chk("sum_state", state, 2'b10);
        chk("sum_res", dut.res, 5'h11);
        chk("sum_ovf", ovf, 1'b1);
        chk("sum_led", led, 1'b1);
        chk("sum_seg", seg, {7'h06, 7'h06});
        sw = 4'h3;
        cyc(5);
        chk("sum_hold_seg", seg, {7'h06, 7'h06});
        press(0);
        chk("back_state", state, 2'b00);
        chk("back_led", led, 1'b0);
        chk("back_ovf", ovf, 1'b0);
        chk("back_seg", seg, {7'h3F, 7'h4F});

        // A bouncing contact must not register until it settles low.
        for (int i = 0; i < 10; i++) begin
            exec_n = ~exec_n;
            cyc(2);
        end
        chk("bounce_state", state, 2'b00);
        exec_n = 1'b0;
        cyc(30);
        chk("held_state", state, 2'b01);
        cyc(20);
        chk("held_once", state, 2'b01);
        exec_n = 1'b1;
        cyc(DB + 8);

        // A=3 (taken during the bounce test) + 7 = 0x0A
        sw = 4'h7;
        press(0);
        chk("sum2_state", state, 2'b10);
        chk("sum2_seg", seg, {7'h3F, 7'h77});
        chk("sum2_ovf", ovf, 1'b0);
        press(1);
        chk("clr_state", state, 2'b00);
        chk("clr_led", led, 1'b0);
        chk("clr_seg", seg, {7'h3F, 7'h07});
        press(0);
        chk("b_state", state, 2'b01);
        press(2);
        chk("clr_wins_state", state, 2'b00);
        chk("clr_wins_a", dut.a, 4'h0);

        // F + F = 0x1E
        sw = 4'hF;
        press(0);
        press(0);
        chk("ff_seg", seg, {7'h06, 7'h79});
        chk("ff_ovf", ovf, 1'b1);
        press(0);

`ifdef TINY_CALC_SUB_EN
        // 3 - 5 = 0xE with borrow
        op = 1'b1;
        sw = 4'h3;
        press(0);
        sw = 4'h5;
        press(0);
        chk("sub_res", dut.res, 5'h0E);
        chk("sub_ovf", ovf, 1'b1);
        chk("sub_seg", seg, {7'h3F, 7'h79});
        op = 1'b0;
        press(0);
`endif

        // 0xFF + 0xFF = 0x1FE on the wide instance
        sw8 = 8'hFF;
        press(3);
        press(3);
        chk("w8_state", state8, 2'b10);
        chk("w8_ovf", ovf8, 1'b1);
        chk("w8_seg", seg8, {7'h06, 7'h71, 7'h79});

        // A reset mid-entry discards the entry at once.
        sw = 4'h2;
        press(0);
        chk("pre_rst_state", state, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 2'b00);
        chk("async_rst_seg", seg, {7'h3F, 7'h3F});
        chk("async_rst_state8", state8, 2'b00);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
